// File: rtl/text_cursor_ctrl.sv
// ============================================================================
// text_cursor_ctrl : UART-to-text-RAM terminal write controller (CR/LF/BS/FF).
// Optional macro TEXT_SCROLL_EN enables ring scrolling via top_row.
// Rev 1.0
// ============================================================================
`default_nettype none

module text_cursor_ctrl #(
  parameter int COLS  = 32,
  parameter int ROWS  = 4,
  parameter int COL_W = 5,
  parameter int ROW_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             dropped,
  output logic             wr_en,
  output logic [ROW_W-1:0] wr_row,
  output logic [COL_W-1:0] wr_col,
  output logic [7:0]       wr_data,
  output logic [ROW_W-1:0] cur_row,
  output logic [COL_W-1:0] cur_col,
  output logic [ROW_W-1:0] top_row
);

  localparam logic [COL_W-1:0] c_LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] c_LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [7:0]       c_SPACE    = 8'h20;

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_WRITE   = 2'd1;
  localparam logic [1:0] c_ST_CLEAR   = 2'd2;
`ifdef TEXT_SCROLL_EN
  localparam logic [1:0] c_ST_CLRLINE = 2'd3;
`endif

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             w_rx_ready;
  logic             r_wr_en;
  logic [ROW_W-1:0] r_wr_row;
  logic [COL_W-1:0] r_wr_col;
  logic [7:0]       r_wr_data;
  logic [ROW_W-1:0] r_cur_row;
  logic [COL_W-1:0] r_cur_col;
  logic             r_cr_seen;
  logic             r_dropped;
  logic [ROW_W-1:0] w_top_row;

  logic             w_is_print;
  logic             w_is_cr;
  logic             w_is_lf;
  logic             w_is_bs;
  logic             w_is_ff;
  logic             w_newline;
  logic             w_bs_block;
  logic             w_clear_last;
  logic [ROW_W-1:0] w_adv_row;
  logic [ROW_W-1:0] w_prev_row;
  logic [ROW_W-1:0] w_bs_row;
  logic [COL_W-1:0] w_bs_col;

  assign w_is_print = (rx_data >= 8'h20) && (rx_data <= 8'h7E);
  assign w_is_cr    = (rx_data == 8'h0D);
  assign w_is_lf    = (rx_data == 8'h0A);
  assign w_is_bs    = (rx_data == 8'h08);
  assign w_is_ff    = (rx_data == 8'h0C);
  // LF directly after CR is the second half of a CRLF pair
  assign w_newline  = w_is_cr | (w_is_lf & ~r_cr_seen);

  assign w_adv_row    = (r_cur_row == c_LAST_ROW) ? '0 : r_cur_row + ROW_W'(1);
  assign w_prev_row   = (r_cur_row == '0) ? c_LAST_ROW : r_cur_row - ROW_W'(1);
  assign w_bs_row     = (r_cur_col == '0) ? w_prev_row : r_cur_row;
  assign w_bs_col     = (r_cur_col == '0) ? c_LAST_COL : r_cur_col - COL_W'(1);
  assign w_bs_block   = (r_cur_row == w_top_row) && (r_cur_col == '0);
  assign w_clear_last = (r_wr_row == c_LAST_ROW) && (r_wr_col == c_LAST_COL);

`ifdef TEXT_SCROLL_EN
  logic [ROW_W-1:0] r_top_row;
  logic             r_scroll_pend;
  logic             w_scroll_hit;
  logic [ROW_W-1:0] w_top_nxt;

  // advancing into the screen's top row means the ring is full
  assign w_scroll_hit = (w_adv_row == r_top_row);
  assign w_top_nxt    = (r_top_row == c_LAST_ROW) ? '0 : r_top_row + ROW_W'(1);
  assign w_top_row    = r_top_row;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_top_row     <= '0;
      r_scroll_pend <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE:
          if (rx_valid && w_is_print)
            r_scroll_pend <= (r_cur_col == c_LAST_COL) && w_scroll_hit;
        c_ST_WRITE:
          r_scroll_pend <= 1'b0;
        c_ST_CLEAR:
          if (w_clear_last) r_top_row <= '0;
        c_ST_CLRLINE:
          if (r_wr_col == c_LAST_COL) r_top_row <= w_top_nxt;
        default: ;
      endcase
    end
  end
`else
  assign w_top_row = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:
        if (rx_valid) begin
          if (w_is_print)                  w_state_nxt = c_ST_WRITE;
          else if (w_is_bs && !w_bs_block) w_state_nxt = c_ST_WRITE;
          else if (w_is_ff)                w_state_nxt = c_ST_CLEAR;
`ifdef TEXT_SCROLL_EN
          else if (w_newline && w_scroll_hit) w_state_nxt = c_ST_CLRLINE;
`endif
        end
      c_ST_WRITE: begin
        w_state_nxt = c_ST_IDLE;
`ifdef TEXT_SCROLL_EN
        if (r_scroll_pend) w_state_nxt = c_ST_CLRLINE;
`endif
      end
      c_ST_CLEAR:
        if (w_clear_last) w_state_nxt = c_ST_IDLE;
`ifdef TEXT_SCROLL_EN
      c_ST_CLRLINE:
        if (r_wr_col == c_LAST_COL) w_state_nxt = c_ST_IDLE;
`endif
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_rx_ready = 1'b0;
    if (r_state == c_ST_IDLE) w_rx_ready = 1'b1;
  end

  // write port doubles as the sweep counter during clear operations
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_en   <= 1'b0;
      r_wr_row  <= '0;
      r_wr_col  <= '0;
      r_wr_data <= '0;
      r_cur_row <= '0;
      r_cur_col <= '0;
      r_cr_seen <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      r_wr_en   <= 1'b0;
      r_dropped <= rx_valid & ~w_rx_ready;
      case (r_state)
        c_ST_IDLE:
          if (rx_valid) begin
            r_cr_seen <= w_is_cr;
            if (w_is_print) begin
              r_wr_en   <= 1'b1;
              r_wr_row  <= r_cur_row;
              r_wr_col  <= r_cur_col;
              r_wr_data <= rx_data;
              if (r_cur_col == c_LAST_COL) begin
                r_cur_col <= '0;
                r_cur_row <= w_adv_row;
              end else begin
                r_cur_col <= r_cur_col + COL_W'(1);
              end
            end else if (w_is_bs) begin
              if (!w_bs_block) begin
                r_wr_en   <= 1'b1;
                r_wr_row  <= w_bs_row;
                r_wr_col  <= w_bs_col;
                r_wr_data <= c_SPACE;
                r_cur_row <= w_bs_row;
                r_cur_col <= w_bs_col;
              end
            end else if (w_is_ff) begin
              r_wr_en   <= 1'b1;
              r_wr_row  <= '0;
              r_wr_col  <= '0;
              r_wr_data <= c_SPACE;
            end else if (w_newline) begin
              r_cur_col <= '0;
              r_cur_row <= w_adv_row;
`ifdef TEXT_SCROLL_EN
              if (w_scroll_hit) begin
                r_wr_en   <= 1'b1;
                r_wr_row  <= w_adv_row;
                r_wr_col  <= '0;
                r_wr_data <= c_SPACE;
              end
`endif
            end
          end
        c_ST_WRITE: begin
`ifdef TEXT_SCROLL_EN
          if (r_scroll_pend) begin
            r_wr_en   <= 1'b1;
            r_wr_row  <= r_cur_row;
            r_wr_col  <= '0;
            r_wr_data <= c_SPACE;
          end
`endif
        end
        c_ST_CLEAR:
          if (w_clear_last) begin
            r_cur_row <= '0;
            r_cur_col <= '0;
          end else begin
            r_wr_en <= 1'b1;
            if (r_wr_col == c_LAST_COL) begin
              r_wr_col <= '0;
              r_wr_row <= r_wr_row + ROW_W'(1);
            end else begin
              r_wr_col <= r_wr_col + COL_W'(1);
            end
          end
`ifdef TEXT_SCROLL_EN
        c_ST_CLRLINE:
          if (r_wr_col != c_LAST_COL) begin
            r_wr_en  <= 1'b1;
            r_wr_col <= r_wr_col + COL_W'(1);
          end
`endif
        default: ;
      endcase
    end
  end

  assign rx_ready = w_rx_ready;
  assign dropped  = r_dropped;
  assign wr_en    = r_wr_en;
  assign wr_row   = r_wr_row;
  assign wr_col   = r_wr_col;
  assign wr_data  = r_wr_data;
  assign cur_row  = r_cur_row;
  assign cur_col  = r_cur_col;
  assign top_row  = w_top_row;

endmodule

`default_nettype wire

// File: tb/tb_text_cursor_ctrl.sv
// tb_text_cursor_ctrl : scoreboard bench for text_cursor_ctrl (32x4 buffer).
`default_nettype none

module tb_text_cursor_ctrl;
  localparam int COLS  = 32;
  localparam int ROWS  = 4;
  localparam int COL_W = 5;
  localparam int ROW_W = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_valid = 1'b0;
  logic             rx_ready;
  logic             dropped;
  logic             wr_en;
  logic [ROW_W-1:0] wr_row;
  logic [COL_W-1:0] wr_col;
  logic [7:0]       wr_data;
  logic [ROW_W-1:0] cur_row;
  logic [COL_W-1:0] cur_col;
  logic [ROW_W-1:0] top_row;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [7:0]       data;
  } wr_t;

  wr_t sb_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  text_cursor_ctrl #(.COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .dropped(dropped), .wr_en(wr_en), .wr_row(wr_row),
    .wr_col(wr_col), .wr_data(wr_data), .cur_row(cur_row), .cur_col(cur_col),
    .top_row(top_row)
  );

  always #5 clk = ~clk;

  task automatic push_wr(input int r, input int c, input logic [7:0] d);
    wr_t e;
    e.row  = ROW_W'(r);
    e.col  = COL_W'(c);
    e.data = d;
    sb_q.push_back(e);
  endtask

  // one clock step; any RAM write seen is popped from the scoreboard and compared
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (wr_en !== 1'b0) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_write: got wr_en=%b row=%0d col=%0d data=%h, expected no write",
                 wr_en, wr_row, wr_col, wr_data);
      end else begin
        e = sb_q.pop_front();
        if (wr_en !== 1'b1 || wr_row !== e.row || wr_col !== e.col || wr_data !== e.data) begin
          n_errors++;
          $display("FAIL write_data: got row=%0d col=%0d data=%h, expected row=%0d col=%0d data=%h",
                   wr_row, wr_col, wr_data, e.row, e.col, e.data);
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (rx_ready !== 1'b1 || wr_en !== 1'b0 || dropped !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got rx_ready=%b wr_en=%b dropped=%b, expected 1 0 0", rx_ready, wr_en, dropped);
    end
    n_checks++;
    if (cur_row !== 2'd0 || cur_col !== 5'd0 || top_row !== 2'd0 ||
        wr_row !== 2'd0 || wr_col !== 5'd0 || wr_data !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_regs: got cur=(%0d,%0d) top=%0d wr=(%0d,%0d,%h), expected all zero",
               cur_row, cur_col, top_row, wr_row, wr_col, wr_data);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_print();
    push_wr(0, 0, 8'h41);
    send(8'h41);
    n_checks++;
    if (cur_row !== 2'd0 || cur_col !== 5'd1 || rx_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL print_cursor: got cur=(%0d,%0d) rx_ready=%b, expected (0,1) 0", cur_row, cur_col, rx_ready);
    end
    tick();
    n_checks++;
    if (rx_ready !== 1'b1 || sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL print_ready: got rx_ready=%b pending=%0d, expected 1 0", rx_ready, sb_q.size());
    end
  endtask

  task automatic test_clear();
    int low_cnt = 0;
    for (int i = 0; i < ROWS * COLS; i++) push_wr(i / COLS, i % COLS, 8'h20);
    send(8'h0C);
    if (rx_ready === 1'b0) low_cnt++;
    for (int i = 1; i < ROWS * COLS; i++) begin
      if (i == 10) begin
        rx_data  = 8'h5A;
        rx_valid = 1'b1;
      end
      tick();
      if (i == 10) begin
        rx_valid = 1'b0;
        n_checks++;
        if (dropped !== 1'b1) begin
          n_errors++;
          $display("FAIL clear_dropped: got dropped=%b, expected 1", dropped);
        end
      end
      if (i == 11) begin
        n_checks++;
        if (dropped !== 1'b0) begin
          n_errors++;
          $display("FAIL clear_dropped_pulse: got dropped=%b, expected 0", dropped);
        end
      end
      if (rx_ready === 1'b0) low_cnt++;
    end
    tick();
    n_checks++;
    if (low_cnt != 128 || rx_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL clear_busy: got busy_cycles=%0d rx_ready=%b, expected 128 1", low_cnt, rx_ready);
    end
    n_checks++;
    if (cur_row !== 2'd0 || cur_col !== 5'd0 || top_row !== 2'd0 || sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL clear_end: got cur=(%0d,%0d) top=%0d pending=%0d, expected (0,0) 0 0",
               cur_row, cur_col, top_row, sb_q.size());
    end
  endtask

  task automatic test_wrap_crlf();
    for (int i = 0; i < COLS; i++) begin
      push_wr(0, i, 8'h42);
      send(8'h42);
      tick();
    end
    n_checks++;
    if (cur_row !== 2'd1 || cur_col !== 5'd0 || sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL wrap_cursor: got cur=(%0d,%0d) pending=%0d, expected (1,0) 0", cur_row, cur_col, sb_q.size());
    end
    send(8'h0D);
    send(8'h0A);
    tick();
    n_checks++;
    if (cur_row !== 2'd2 || cur_col !== 5'd0) begin
      n_errors++;
      $display("FAIL crlf_cursor: got cur=(%0d,%0d), expected (2,0)", cur_row, cur_col);
    end
  endtask

  task automatic test_backspace();
    push_wr(1, 31, 8'h20);
    send(8'h08);
    n_checks++;
    if (cur_row !== 2'd1 || cur_col !== 5'd31) begin
      n_errors++;
      $display("FAIL bs_rowback: got cur=(%0d,%0d), expected (1,31)", cur_row, cur_col);
    end
    tick();
    push_wr(1, 30, 8'h20);
    send(8'h08);
    n_checks++;
    if (cur_row !== 2'd1 || cur_col !== 5'd30) begin
      n_errors++;
      $display("FAIL bs_colback: got cur=(%0d,%0d), expected (1,30)", cur_row, cur_col);
    end
    tick();
    send(8'h0A);
    tick();
    n_checks++;
    if (cur_row !== 2'd2 || cur_col !== 5'd0 || sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL lone_lf: got cur=(%0d,%0d) pending=%0d, expected (2,0) 0", cur_row, cur_col, sb_q.size());
    end
  endtask

  task automatic test_reset_mid_clear();
    for (int i = 0; i <= 40; i++) push_wr(i / COLS, i % COLS, 8'h20);
    send(8'h0C);
    repeat (40) tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (wr_en !== 1'b0 || cur_row !== 2'd0 || cur_col !== 5'd0 || sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL abort_clear: got wr_en=%b cur=(%0d,%0d) pending=%0d, expected 0 (0,0) 0",
               wr_en, cur_row, cur_col, sb_q.size());
    end
    repeat (2) tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if (rx_ready !== 1'b1 || wr_en !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_release: got rx_ready=%b wr_en=%b, expected 1 0", rx_ready, wr_en);
    end
  endtask

  task automatic test_origin_and_ignored();
    send(8'h08);
    n_checks++;
    if (cur_row !== 2'd0 || cur_col !== 5'd0 || rx_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL bs_origin: got cur=(%0d,%0d) rx_ready=%b, expected (0,0) 1", cur_row, cur_col, rx_ready);
    end
    tick();
    send(8'h7F);
    send(8'h01);
    send(8'hC3);
    tick();
    n_checks++;
    if (cur_row !== 2'd0 || cur_col !== 5'd0 || rx_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL ignored_bytes: got cur=(%0d,%0d) rx_ready=%b, expected (0,0) 1", cur_row, cur_col, rx_ready);
    end
  endtask

  task automatic test_row_wrap();
    repeat (3) send(8'h0D);
    for (int i = 0; i < 5; i++) begin
      push_wr(3, i, 8'h78);
      send(8'h78);
      tick();
    end
    n_checks++;
    if (cur_row !== 2'd3 || cur_col !== 5'd5) begin
      n_errors++;
      $display("FAIL pre_wrap: got cur=(%0d,%0d), expected (3,5)", cur_row, cur_col);
    end
`ifdef TEXT_SCROLL_EN
    for (int i = 0; i < COLS; i++) push_wr(0, i, 8'h20);
    send(8'h0D);
    repeat (COLS) tick();
    n_checks++;
    if (cur_row !== 2'd0 || cur_col !== 5'd0 || top_row !== 2'd1 || rx_ready !== 1'b1 || sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scroll: got cur=(%0d,%0d) top=%0d rx_ready=%b pending=%0d, expected (0,0) 1 1 0",
               cur_row, cur_col, top_row, rx_ready, sb_q.size());
    end
`else
    send(8'h0D);
    tick();
    n_checks++;
    if (cur_row !== 2'd0 || cur_col !== 5'd0 || top_row !== 2'd0 || rx_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL row_wrap: got cur=(%0d,%0d) top=%0d rx_ready=%b, expected (0,0) 0 1",
               cur_row, cur_col, top_row, rx_ready);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_print();
    test_clear();
    test_wrap_crlf();
    test_backspace();
    test_reset_mid_clear();
    test_origin_and_ignored();
    test_row_wrap();
    repeat (3) tick();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL missing_writes: got %0d expected writes never seen, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
